// File: rtl/l2_mem_port_arbiter_pkg.sv
// Shared definitions for the L2 memory port arbiter: FSM encoding and default widths.
// Widths mirror the cache headers (DADDR_bits, DL2block/DL2subblocks, DL2subblocks_Log2).
// No logic here; helper function is pure arithmetic.
package l2_mem_port_arbiter_pkg;

  localparam int DADDR_BITS   = 32;
  localparam int DL2_SUB_W    = 64;
  localparam int DL2_SUB_LOG2 = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

  // Next round-robin start point: one past idx, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/l2_mem_port_arbiter_rr_pick.sv
// Purpose: round-robin pick of the first set request at or after ptr (wrapping).
// Latency: purely combinational.
// Backpressure: none; valid is low when no request is set.
module l2_mem_port_arbiter_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from ptr upward; the first hit is the winner.
  always_comb begin
    int               j;
    logic [IDX_W-1:0] jj;
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    j      = 0;
    jj     = '0;
    for (int k = 0; k < N; k++) begin
      j  = (int'(ptr) + k) % N;
      jj = IDX_W'(j);
      if (!valid && req[jj]) begin
        valid      = 1'b1;
        onehot[jj] = 1'b1;
        idx        = jj;
      end
    end
  end

endmodule

// File: rtl/l2_mem_port_arbiter.sv
// Purpose: shares one memory block port among N_REQ L2s (round-robin, grant held per block) and sequences flush.
// Latency: 1 cycle arbitration (r_en -> m_en); write/read subblock streams pass through combinationally.
// Backpressure: requesters hold r_en until r_ready; memory paces beats with m_accR/m_accW/m_ready.
module l2_mem_port_arbiter
  import l2_mem_port_arbiter_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int ADDR_W   = DADDR_BITS,
  parameter int SUB_W    = DL2_SUB_W,
  parameter int SUB_LOG2 = DL2_SUB_LOG2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ*ADDR_W-1:0]   r_addr,
  input  logic [N_REQ-1:0]          r_en,
  input  logic [N_REQ-1:0]          r_we,
  input  logic [N_REQ*SUB_LOG2-1:0] r_wstrobe,
  input  logic [N_REQ*SUB_W-1:0]    r_wdata,
  output logic [SUB_LOG2-1:0]       r_rstrobe,
  output logic [SUB_W-1:0]          r_rdata,
  output logic [N_REQ-1:0]          r_ready,
  output logic [N_REQ-1:0]          r_accR,
  output logic [N_REQ-1:0]          r_accW,
  output logic [N_REQ-1:0]          r_flush,
  input  logic [N_REQ-1:0]          r_flushed,
  output logic [ADDR_W-1:0]         m_addr,
  output logic                      m_en,
  output logic                      m_we,
  output logic [SUB_LOG2-1:0]       m_wstrobe,
  output logic [SUB_W-1:0]          m_wdata,
  input  logic [SUB_LOG2-1:0]       m_rstrobe,
  input  logic [SUB_W-1:0]          m_rdata,
  input  logic                      m_ready,
  input  logic                      m_accR,
  input  logic                      m_accW,
  input  logic                      flush,
  output logic                      flushed
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t         state, state_nxt;
  logic [IDX_W-1:0]   grant;
  logic [N_REQ-1:0]   grant_oh;
  logic [IDX_W-1:0]   rr_ptr;
  logic [N_REQ-1:0]   pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_vld;
  logic               load_grant;
  logic               done;
  logic               busy;
  logic [N_REQ-1:0]   flushed_seen;

  l2_mem_port_arbiter_rr_pick #(.N(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req    (r_en),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_vld)
  );

  // Next state. RELEASE also arbitrates: r_en sampled at its end already reflects the
  // finished requester's deassertion, so back-to-back grants are one idle cycle apart.
  always_comb begin
    state_nxt  = state;
    load_grant = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE, ST_RELEASE: begin
        if (pick_vld) begin
          state_nxt  = ST_BUSY;
          load_grant = 1'b1;
        end else begin
          state_nxt  = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (m_ready) begin
          state_nxt = ST_RELEASE;
          done      = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, grant and round-robin pointer; grant is frozen for the whole BUSY phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      grant    <= '0;
      grant_oh <= '0;
      rr_ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (load_grant) begin
        grant    <= pick_idx;
        grant_oh <= pick_onehot;
      end
      if (done) begin
        rr_ptr <= IDX_W'(rr_next(32'(grant), 32'(N_REQ)));
      end
    end
  end

  assign busy = (state == ST_BUSY);
  assign m_en = busy;

  // Request-side mux into the memory port; memory responses go back to the granted bit only.
  always_comb begin
    m_addr    = r_addr[grant*ADDR_W +: ADDR_W];
    m_we      = r_we[grant];
    m_wstrobe = r_wstrobe[grant*SUB_LOG2 +: SUB_LOG2];
    m_wdata   = r_wdata[grant*SUB_W +: SUB_W];
    r_ready   = done              ? grant_oh : '0;
    r_accR    = (busy && m_accR)  ? grant_oh : '0;
    r_accW    = (busy && m_accW)  ? grant_oh : '0;
    r_rstrobe = m_rstrobe;
    r_rdata   = m_rdata;
  end

  // Flush broadcast and aggregation; flushed rises on the edge that sees the last L2 done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flush      <= '0;
      flushed_seen <= '0;
      flushed      <= 1'b0;
    end else begin
      r_flush <= {N_REQ{flush}};
      if (flush) begin
        flushed_seen <= flushed_seen | r_flushed;
        flushed      <= &(flushed_seen | r_flushed);
      end else begin
        flushed_seen <= '0;
        flushed      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_l2_mem_port_arbiter.sv
module tb_l2_mem_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int SW = 64;
  localparam int SL = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [N*AW-1:0] r_addr;
  logic [N-1:0]    r_en, r_we;
  logic [N*SL-1:0] r_wstrobe;
  logic [N*SW-1:0] r_wdata;
  logic [SL-1:0]   r_rstrobe;
  logic [SW-1:0]   r_rdata;
  logic [N-1:0]    r_ready, r_accR, r_accW, r_flush, r_flushed;
  logic [AW-1:0]   m_addr;
  logic            m_en, m_we;
  logic [SL-1:0]   m_wstrobe;
  logic [SW-1:0]   m_wdata;
  logic [SL-1:0]   m_rstrobe;
  logic [SW-1:0]   m_rdata;
  logic            m_ready, m_accR, m_accW, flush, flushed;

  int n_cmp = 0;
  int n_bad = 0;
  logic [AW-1:0] addr_of [N];

  always #5 clk = ~clk;

  l2_mem_port_arbiter #(.N_REQ(N), .ADDR_W(AW), .SUB_W(SW), .SUB_LOG2(SL)) dut (
    .clk(clk), .reset(reset),
    .r_addr(r_addr), .r_en(r_en), .r_we(r_we), .r_wstrobe(r_wstrobe), .r_wdata(r_wdata),
    .r_rstrobe(r_rstrobe), .r_rdata(r_rdata), .r_ready(r_ready), .r_accR(r_accR), .r_accW(r_accW),
    .r_flush(r_flush), .r_flushed(r_flushed),
    .m_addr(m_addr), .m_en(m_en), .m_we(m_we), .m_wstrobe(m_wstrobe), .m_wdata(m_wdata),
    .m_rstrobe(m_rstrobe), .m_rdata(m_rdata), .m_ready(m_ready), .m_accR(m_accR), .m_accW(m_accW),
    .flush(flush), .flushed(flushed)
  );

  // Reference arbitration rule: first pending index scanning up from ptr, wrapping.
  function automatic int rr_winner(input logic [N-1:0] pend, input int ptr);
    logic [N-1:0] sh;
    for (int k = 0; k < N; k++) begin
      sh = pend >> ((ptr + k) % N);
      if (sh[0]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // Memory-side responder: waits (bounded) for m_en, runs nbeats read beats, pulses m_ready,
  // then in the RELEASE cycle drops the served requester unless keep is set.
  task automatic serve(input int nbeats, input bit keep, output bit tmo, output int gnt,
                       output logic [N-1:0] rdy, output int gap);
    tmo = 1'b0; gap = 0; gnt = 0; rdy = '0;
    while (m_en !== 1'b1) begin
      if (gap >= 20) begin tmo = 1'b1; return; end
      @(negedge clk); #1; gap++;
    end
    gnt = int'(m_addr[31:24]);
    for (int k = 0; k < nbeats; k++) begin
      m_accR = 1'b1; m_rstrobe = SL'(k); m_rdata = {$urandom, $urandom};
      @(negedge clk); #1;
    end
    m_accR = 1'b0; m_ready = 1'b1; #1;
    rdy = r_ready;
    @(negedge clk);
    m_ready = 1'b0;
    if (!keep && gnt < N) r_en[gnt] = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; r_en = '1; m_ready = 1'b1; m_accR = 1'b1; m_accW = 1'b1; flush = 1'b1; r_flushed = '1;
    repeat (2) @(negedge clk); #1;
    n_cmp++; if (m_en !== 1'b0)    begin n_bad++; $display("FAIL reset_m_en: got %0b want 0", m_en); end
    n_cmp++; if (r_ready !== '0)   begin n_bad++; $display("FAIL reset_r_ready: got %0h want 0", r_ready); end
    n_cmp++; if (r_accR !== '0)    begin n_bad++; $display("FAIL reset_r_accR: got %0h want 0", r_accR); end
    n_cmp++; if (r_accW !== '0)    begin n_bad++; $display("FAIL reset_r_accW: got %0h want 0", r_accW); end
    n_cmp++; if (r_flush !== '0)   begin n_bad++; $display("FAIL reset_r_flush: got %0h want 0", r_flush); end
    n_cmp++; if (flushed !== 1'b0) begin n_bad++; $display("FAIL reset_flushed: got %0b want 0", flushed); end
    n_cmp++; if (dut.rr_ptr !== 2'd0) begin n_bad++; $display("FAIL reset_rr_ptr: got %0d want 0", dut.rr_ptr); end
    n_cmp++; if (dut.grant !== 2'd0)  begin n_bad++; $display("FAIL reset_grant: got %0d want 0", dut.grant); end
    r_en = '0; m_ready = 1'b0; m_accR = 1'b0; m_accW = 1'b0; flush = 1'b0; r_flushed = '0;
    reset = 1'b1;
    @(negedge clk); #1;
  endtask

  task automatic test_single_read;
    logic [SW-1:0] d;
    r_we[2] = 1'b0; r_en[2] = 1'b1; #1;
    n_cmp++; if (m_en !== 1'b0) begin n_bad++; $display("FAIL rd_arb_cycle: m_en got %0b want 0", m_en); end
    @(negedge clk); #1;
    n_cmp++; if (m_en !== 1'b1) begin n_bad++; $display("FAIL rd_m_en_rise: got %0b want 1", m_en); end
    n_cmp++; if (m_addr !== addr_of[2]) begin n_bad++; $display("FAIL rd_m_addr: got %0h want %0h", m_addr, addr_of[2]); end
    for (int k = 0; k < 8; k++) begin
      if (k == 3) begin
        m_accR = 1'b0; #1;
        n_cmp++; if (r_accR !== 4'b0000) begin n_bad++; $display("FAIL rd_stall_accR: got %0h want 0", r_accR); end
        @(negedge clk); #1;
      end
      d = {$urandom, $urandom};
      m_accR = 1'b1; m_rstrobe = SL'(k); m_rdata = d; #1;
      n_cmp++; if (r_accR !== 4'b0100) begin n_bad++; $display("FAIL rd_accR beat %0d: got %0h want 4", k, r_accR); end
      n_cmp++; if (r_rstrobe !== SL'(k)) begin n_bad++; $display("FAIL rd_rstrobe beat %0d: got %0d want %0d", k, r_rstrobe, k); end
      n_cmp++; if (r_rdata !== d) begin n_bad++; $display("FAIL rd_rdata beat %0d: got %0h want %0h", k, r_rdata, d); end
      n_cmp++; if (r_ready !== 4'b0000) begin n_bad++; $display("FAIL rd_early_ready beat %0d: got %0h want 0", k, r_ready); end
      @(negedge clk); #1;
    end
    m_accR = 1'b0; m_ready = 1'b1; #1;
    n_cmp++; if (r_ready !== 4'b0100) begin n_bad++; $display("FAIL rd_ready: got %0h want 4", r_ready); end
    @(negedge clk); m_ready = 1'b0; r_en[2] = 1'b0; #1;
    n_cmp++; if (m_en !== 1'b0)    begin n_bad++; $display("FAIL rd_release_m_en: got %0b want 0", m_en); end
    n_cmp++; if (r_ready !== '0)   begin n_bad++; $display("FAIL rd_ready_once: got %0h want 0", r_ready); end
    n_cmp++; if (dut.rr_ptr !== 2'd3) begin n_bad++; $display("FAIL rd_rr_ptr: got %0d want 3", dut.rr_ptr); end
    @(negedge clk); #1;
    n_cmp++; if (m_en !== 1'b0) begin n_bad++; $display("FAIL rd_idle_m_en: got %0b want 0", m_en); end
  endtask

  task automatic test_simultaneous;
    logic [N-1:0] pend, rdy;
    int ptr, w, gnt, gap;
    bit tmo;
    test_reset();
    pend = 4'b1011; ptr = 0; r_en = pend;
    for (int t = 0; t < 3; t++) begin
      w = rr_winner(pend, ptr);
      serve($urandom_range(1, 4), 1'b0, tmo, gnt, rdy, gap);
      n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL sim_timeout t%0d: got 1 want 0", t); end
      n_cmp++; if (gnt != w) begin n_bad++; $display("FAIL sim_grant t%0d: got %0d want %0d", t, gnt, w); end
      n_cmp++; if (rdy !== (N'(1) << w)) begin n_bad++; $display("FAIL sim_ready t%0d: got %0h want %0h", t, rdy, N'(1) << w); end
      n_cmp++; if (gap != 1) begin n_bad++; $display("FAIL sim_gap t%0d: got %0d want 1", t, gap); end
      pend[w] = 1'b0; ptr = (w + 1) % N;
    end
  endtask

  task automatic test_write;
    logic [SW-1:0] exp_d;
    logic [N-1:0]  exp_w;
    int g;
    r_we[1] = 1'b1; r_en[1] = 1'b1; g = 0;
    while (m_en !== 1'b1 && g < 10) begin @(negedge clk); #1; g++; end
    n_cmp++; if (g != 1) begin n_bad++; $display("FAIL wr_latency: got %0d want 1", g); end
    n_cmp++; if (m_we !== 1'b1) begin n_bad++; $display("FAIL wr_m_we: got %0b want 1", m_we); end
    for (int k = 0; k < 8; k++) begin
      exp_d = 64'hDEAD_BEEF_0000_0000 | 64'(k);
      r_wstrobe[SL +: SL] = SL'(k);
      r_wdata[SW +: SW]   = exp_d;
      m_accW = 1'($urandom_range(0, 1));
      exp_w  = m_accW ? 4'b0010 : 4'b0000;
      #1;
      n_cmp++; if (m_wstrobe !== SL'(k)) begin n_bad++; $display("FAIL wr_wstrobe k%0d: got %0d want %0d", k, m_wstrobe, k); end
      n_cmp++; if (m_wdata !== exp_d) begin n_bad++; $display("FAIL wr_wdata k%0d: got %0h want %0h", k, m_wdata, exp_d); end
      n_cmp++; if (r_accW !== exp_w) begin n_bad++; $display("FAIL wr_accW k%0d: got %0h want %0h", k, r_accW, exp_w); end
      @(negedge clk); #1;
    end
    m_accW = 1'b0; m_ready = 1'b1; #1;
    n_cmp++; if (r_ready !== 4'b0010) begin n_bad++; $display("FAIL wr_ready: got %0h want 2", r_ready); end
    @(negedge clk); m_ready = 1'b0; r_en[1] = 1'b0; r_we[1] = 1'b0; #1;
  endtask

  task automatic test_back_to_back;
    logic [N-1:0] rdy;
    int ptr, w, gnt, gap, maxw;
    int since [N];
    bit tmo;
    test_reset();
    r_en = '1; ptr = 0; maxw = 0;
    for (int i = 0; i < N; i++) since[i] = 0;
    for (int t = 0; t < 12; t++) begin
      w = rr_winner(4'b1111, ptr);
      serve($urandom_range(1, 3), 1'b1, tmo, gnt, rdy, gap);
      n_cmp++; if (gnt != w || tmo) begin n_bad++; $display("FAIL b2b_grant t%0d: got %0d want %0d", t, gnt, w); end
      n_cmp++; if (gap != 1) begin n_bad++; $display("FAIL b2b_gap t%0d: got %0d want 1", t, gap); end
      for (int i = 0; i < N; i++) begin
        if (i == gnt) since[i] = 0; else since[i]++;
        if (since[i] > maxw) maxw = since[i];
      end
      ptr = (w + 1) % N;
    end
    n_cmp++; if (maxw > N - 1) begin n_bad++; $display("FAIL b2b_max_wait: got %0d want <= %0d", maxw, N - 1); end
    r_en = '0;
    @(negedge clk); #1;
  endtask

  task automatic test_flush;
    int order [4] = '{0, 2, 1, 3};
    flush = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (r_flush !== 4'b1111) begin n_bad++; $display("FAIL fl_r_flush: got %0h want f", r_flush); end
    for (int j = 0; j < 4; j++) begin
      r_flushed[order[j]] = 1'b1;
      if (j < 3) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        #1;
        n_cmp++; if (flushed !== 1'b0) begin n_bad++; $display("FAIL fl_early j%0d: got %0b want 0", j, flushed); end
      end
    end
    #1;
    n_cmp++; if (flushed !== 1'b0) begin n_bad++; $display("FAIL fl_same_cycle: got %0b want 0", flushed); end
    @(negedge clk); #1;
    n_cmp++; if (flushed !== 1'b1) begin n_bad++; $display("FAIL fl_done: got %0b want 1", flushed); end
    flush = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (flushed !== 1'b0) begin n_bad++; $display("FAIL fl_clear: got %0b want 0", flushed); end
    n_cmp++; if (r_flush !== 4'b0000) begin n_bad++; $display("FAIL fl_r_flush_off: got %0h want 0", r_flush); end
    r_flushed = '0; flush = 1'b1;
    repeat (2) @(negedge clk); #1;
    n_cmp++; if (flushed !== 1'b0) begin n_bad++; $display("FAIL fl_seen_cleared: got %0b want 0", flushed); end
    flush = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic test_random;
    logic [N-1:0] pend, nreq, rdy;
    int ptr, w, gnt, gap;
    bit tmo;
    test_reset();
    pend = '0; ptr = 0;
    for (int t = 0; t < 20; t++) begin
      nreq = N'($urandom);
      if ((pend | nreq) == '0) nreq[$urandom_range(0, N - 1)] = 1'b1;
      pend = pend | nreq; r_en = r_en | nreq;
      flush = 1'($urandom_range(0, 1));
      w = rr_winner(pend, ptr);
      serve($urandom_range(1, 8), 1'b0, tmo, gnt, rdy, gap);
      n_cmp++; if (gnt != w || tmo) begin n_bad++; $display("FAIL rnd_grant t%0d: got %0d want %0d", t, gnt, w); end
      n_cmp++; if (rdy !== (N'(1) << w)) begin n_bad++; $display("FAIL rnd_ready t%0d: got %0h want %0h", t, rdy, N'(1) << w); end
      n_cmp++; if (gap != 1) begin n_bad++; $display("FAIL rnd_gap t%0d: got %0d want 1", t, gap); end
      pend[w] = 1'b0; ptr = (w + 1) % N;
    end
    flush = 1'b0; r_en = '0;
    @(negedge clk); #1;
  endtask

  task automatic test_reset_mid;
    logic [N-1:0] rdy;
    int gnt, gap, g;
    bit tmo;
    r_en[1] = 1'b1;
    serve(2, 1'b0, tmo, gnt, rdy, gap);
    r_en[2] = 1'b1; g = 0;
    while (m_en !== 1'b1 && g < 10) begin @(negedge clk); #1; g++; end
    for (int k = 0; k < 4; k++) begin
      m_accR = 1'b1; m_rstrobe = SL'(k);
      @(negedge clk); #1;
    end
    reset = 1'b0; m_accR = 1'b1; m_ready = 1'b1; #1;
    n_cmp++; if (m_en !== 1'b0)    begin n_bad++; $display("FAIL rst_mid_m_en: got %0b want 0", m_en); end
    n_cmp++; if (r_ready !== '0)   begin n_bad++; $display("FAIL rst_mid_r_ready: got %0h want 0", r_ready); end
    n_cmp++; if (r_accR !== '0)    begin n_bad++; $display("FAIL rst_mid_r_accR: got %0h want 0", r_accR); end
    m_accR = 1'b0; m_ready = 1'b0; r_en = '0;
    @(negedge clk); reset = 1'b1; #1;
    n_cmp++; if (dut.rr_ptr !== 2'd0) begin n_bad++; $display("FAIL rst_mid_rr_ptr: got %0d want 0", dut.rr_ptr); end
    r_en = 4'b1001;
    serve(3, 1'b0, tmo, gnt, rdy, gap);
    n_cmp++; if (gnt != 0 || tmo) begin n_bad++; $display("FAIL rst_mid_grant: got %0d want 0", gnt); end
    n_cmp++; if (rdy !== 4'b0001) begin n_bad++; $display("FAIL rst_mid_ready: got %0h want 1", rdy); end
    n_cmp++; if (gap != 1) begin n_bad++; $display("FAIL rst_mid_gap: got %0d want 1", gap); end
    r_en = '0;
    @(negedge clk); #1;
  endtask

  initial begin
    reset = 1'b0; r_en = '0; r_we = '0; r_wstrobe = '0; r_wdata = '0; r_flushed = '0;
    m_rstrobe = '0; m_rdata = '0; m_ready = 1'b0; m_accR = 1'b0; m_accW = 1'b0; flush = 1'b0;
    for (int i = 0; i < N; i++) begin
      addr_of[i] = {8'(i), 24'($urandom)};
      r_addr[i*AW +: AW] = addr_of[i];
    end
    @(negedge clk); #1;
    test_reset();
    test_single_read();
    test_simultaneous();
    test_write();
    test_back_to_back();
    test_flush();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
